// File: rtl/int_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// int_pkg : shared FSM encoding and default sizes for the interrupt controller
// Rev 1.0
// ---------------------------------------------------------------------------
package int_pkg;

  localparam int NINT_DEF  = 4;
  localparam int IDW_DEF   = 2;
  localparam int INT_TIMER = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/int_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// int_ctrl_if : peripheral lines and CPU handshake of the interrupt controller
// Rev 1.0
// ---------------------------------------------------------------------------
interface int_ctrl_if
  import int_pkg::*;
#(
  parameter int NINT = NINT_DEF,
  parameter int IDW  = IDW_DEF
) ();

  logic [NINT-1:0] irq_in;
  logic            ien_we;
  logic [NINT-1:0] ien_d;
  logic            int_ack;
  logic            int_eoi;
  logic            int_req;
  logic [IDW-1:0]  int_id;
  logic [NINT-1:0] pending;
  logic [NINT-1:0] ien;
  logic            busy;

  modport master (
    output irq_in, ien_we, ien_d, int_ack, int_eoi,
    input  int_req, int_id, pending, ien, busy
  );

  modport slave (
    input  irq_in, ien_we, ien_d, int_ack, int_eoi,
    output int_req, int_id, pending, ien, busy
  );

endinterface
`default_nettype wire

// File: rtl/int_sync_edge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// int_sync_edge : per-line 2-flop synchroniser plus rising-edge detector
// Rev 1.0
// ---------------------------------------------------------------------------
module int_sync_edge
  import int_pkg::*;
#(
  parameter int NINT = NINT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NINT-1:0] irq_i,
  output logic [NINT-1:0] rise_o
);

  logic [NINT-1:0] s1_q, s2_q, prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= irq_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/int_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// int_ctrl : fixed-priority interrupt controller (lowest index wins).
// Define INT_NESTING_EN to allow preemption by higher-priority lines.
// Rev 1.0
// ---------------------------------------------------------------------------
module int_ctrl
  import int_pkg::*;
#(
  parameter int NINT = NINT_DEF,
  parameter int IDW  = IDW_DEF
) (
  input  logic       clk,
  input  logic       reset,
  int_ctrl_if.slave  bus
);

  function automatic logic [IDW-1:0] prio_enc(input logic [NINT-1:0] v);
    prio_enc = '0;
    for (int i = NINT - 1; i >= 0; i--)
      if (v[i]) prio_enc = IDW'(i);
  endfunction

  logic [NINT-1:0] rise;

  int_sync_edge #(.NINT(NINT)) u_sync (
    .clk    (clk),
    .reset  (reset),
    .irq_i  (bus.irq_in),
    .rise_o (rise)
  );

  state_t          state_q, state_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [NINT-1:0] pend_q, pend_d;
  logic [NINT-1:0] ien_q, ien_d;
  logic [NINT-1:0] elig, id_onehot, ack_clr;
  logic            ack_take;

`ifdef INT_NESTING_EN
  logic [NINT-1:0] isr_q, isr_d, isr_low, preempt;
  assign isr_low = isr_q & (~isr_q + 1'b1);
  // Only lines strictly above the highest-priority in-service line may preempt.
  assign preempt = elig & (isr_low - 1'b1);
`else
  logic busy_q, busy_d;
`endif

  assign elig      = pend_q & ien_q;
  assign id_onehot = {{(NINT-1){1'b0}}, 1'b1} << id_q;
  assign ack_take  = (state_q == REQ) && bus.int_ack;
  assign ack_clr   = ack_take ? id_onehot : '0;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ien_d   = bus.ien_we ? bus.ien_d : ien_q;
    // A rise coincident with the acknowledge of the same line keeps it pending.
    pend_d  = (pend_q & ~ack_clr) | rise;
`ifdef INT_NESTING_EN
    isr_d   = isr_q;
`else
    busy_d  = busy_q;
`endif
    case (state_q)
      IDLE: begin
        if (|elig) begin
          state_d = REQ;
          id_d    = prio_enc(elig);
        end
      end
      REQ: begin
        if (bus.int_ack) begin
          state_d = SERVICE;
`ifdef INT_NESTING_EN
          isr_d   = isr_q | id_onehot;
`else
          busy_d  = 1'b1;
`endif
        end else if (bus.ien_we && !bus.ien_d[id_q]) begin
`ifdef INT_NESTING_EN
          state_d = (|isr_q) ? SERVICE : IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
      SERVICE: begin
`ifdef INT_NESTING_EN
        if (bus.int_eoi) begin
          isr_d = isr_q & ~isr_low;
          if (isr_d == '0) state_d = IDLE;
        end else if (|preempt) begin
          state_d = REQ;
          id_d    = prio_enc(preempt);
        end
`else
        if (bus.int_eoi) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      id_q    <= '0;
      pend_q  <= '0;
      ien_q   <= '0;
`ifdef INT_NESTING_EN
      isr_q   <= '0;
`else
      busy_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      pend_q  <= pend_d;
      ien_q   <= ien_d;
`ifdef INT_NESTING_EN
      isr_q   <= isr_d;
`else
      busy_q  <= busy_d;
`endif
    end
  end

  assign bus.int_req = (state_q == REQ);
  assign bus.int_id  = id_q;
  assign bus.pending = pend_q;
  assign bus.ien     = ien_q;
`ifdef INT_NESTING_EN
  assign bus.busy    = |isr_q;
`else
  assign bus.busy    = busy_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_int_ctrl : directed self-checking bench for int_ctrl (default build)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_int_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  int_ctrl_if #(.NINT(4), .IDW(2)) bus ();

  int_ctrl #(.NINT(4), .IDW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus.irq_in  = '0;
    bus.ien_we  = 1'b0;
    bus.ien_d   = '0;
    bus.int_ack = 1'b0;
    bus.int_eoi = 1'b0;
    tick(); tick();
    check("rst_req",  bus.int_req, 0);
    check("rst_id",   bus.int_id,  0);
    check("rst_pend", bus.pending, 0);
    check("rst_ien",  bus.ien,     0);
    check("rst_busy", bus.busy,    0);
    reset = 1'b0;
    tick();

    // single timer pulse, latency and ack/eoi
    bus.ien_we = 1'b1; bus.ien_d = 4'hF; tick(); bus.ien_we = 1'b0;
    check("ien_write", bus.ien, 4'hF);
    bus.irq_in = 4'b0001; tick(); bus.irq_in = '0;
    tick();
    check("t1_pend_k1", bus.pending, 4'b0000);
    tick();
    check("t1_pend_k2", bus.pending, 4'b0001);
    check("t1_req_k2",  bus.int_req, 0);
    tick();
    check("t1_req_k3",  bus.int_req, 1);
    check("t1_id_k3",   bus.int_id,  0);
    bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
    check("t1_pend_ack", bus.pending, 4'b0000);
    check("t1_busy_ack", bus.busy,    1);
    check("t1_req_svc",  bus.int_req, 0);
    bus.int_eoi = 1'b1; tick(); bus.int_eoi = 1'b0;
    check("t1_busy_eoi", bus.busy,    0);
    check("t1_req_eoi",  bus.int_req, 0);
    tick();
    check("t1_req_idle", bus.int_req, 0);

    // simultaneous lines 3 and 1
    bus.irq_in = 4'b1010; tick(); bus.irq_in = '0;
    tick(); tick();
    check("t2_pend", bus.pending, 4'b1010);
    tick();
    check("t2_req1", bus.int_req, 1);
    check("t2_id1",  bus.int_id,  1);
    bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
    check("t2_pend_ack", bus.pending, 4'b1000);
    bus.int_eoi = 1'b1; tick(); bus.int_eoi = 1'b0;
    check("t2_req_gap", bus.int_req, 0);
    tick();
    check("t2_req3", bus.int_req, 1);
    check("t2_id3",  bus.int_id,  3);
    bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
    bus.int_eoi = 1'b1; tick(); bus.int_eoi = 1'b0;
    check("t2_pend_end", bus.pending, 4'b0000);
    check("t2_busy_end", bus.busy,    0);

    // rise while disabled, then enable
    bus.ien_we = 1'b1; bus.ien_d = 4'b0000; tick(); bus.ien_we = 1'b0;
    bus.irq_in = 4'b0100; tick(); bus.irq_in = '0;
    tick(); tick();
    check("t3_pend", bus.pending, 4'b0100);
    check("t3_req0", bus.int_req, 0);
    tick();
    check("t3_req0b", bus.int_req, 0);
    bus.ien_we = 1'b1; bus.ien_d = 4'b0100; tick(); bus.ien_we = 1'b0;
    check("t3_req_w", bus.int_req, 0);
    tick();
    check("t3_req2", bus.int_req, 1);
    check("t3_id2",  bus.int_id,  2);

    // withdraw by disable, then disable coincident with ack
    bus.ien_we = 1'b1; bus.ien_d = 4'b0000; tick(); bus.ien_we = 1'b0;
    check("t4_withdraw", bus.int_req, 0);
    check("t4_pend",     bus.pending, 4'b0100);
    tick();
    check("t4_idle", bus.int_req, 0);
    bus.ien_we = 1'b1; bus.ien_d = 4'b0100; tick(); bus.ien_we = 1'b0;
    tick();
    check("t4_req2", bus.int_req, 1);
    bus.ien_we = 1'b1; bus.ien_d = 4'b0000; bus.int_ack = 1'b1;
    tick();
    bus.ien_we = 1'b0; bus.int_ack = 1'b0;
    check("t4_ack_busy", bus.busy,    1);
    check("t4_ack_pend", bus.pending, 4'b0000);
    check("t4_ack_req",  bus.int_req, 0);
    check("t4_ack_ien",  bus.ien,     4'b0000);
    bus.int_eoi = 1'b1; tick(); bus.int_eoi = 1'b0;
    check("t4_eoi_busy", bus.busy, 0);

    // timer rises during service of line 3: no preemption
    bus.ien_we = 1'b1; bus.ien_d = 4'hF; tick(); bus.ien_we = 1'b0;
    bus.irq_in = 4'b1000; tick(); bus.irq_in = '0;
    tick(); tick(); tick();
    check("t5_req3", bus.int_req, 1);
    check("t5_id3",  bus.int_id,  3);
    bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
    check("t5_busy", bus.busy, 1);
    bus.irq_in = 4'b0001; tick(); bus.irq_in = '0;
    tick(); tick();
    check("t5_pend0", bus.pending, 4'b0001);
    check("t5_noreq", bus.int_req, 0);
    tick(); tick();
    check("t5_noreq2", bus.int_req, 0);
    bus.int_eoi = 1'b1; tick(); bus.int_eoi = 1'b0;
    check("t5_eoi_busy", bus.busy,    0);
    check("t5_eoi_req",  bus.int_req, 0);
    tick();
    check("t5_req0", bus.int_req, 1);
    check("t5_id0",  bus.int_id,  0);
    bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
    bus.int_eoi = 1'b1; tick(); bus.int_eoi = 1'b0;
    check("t5_pend_end", bus.pending, 4'b0000);

    // async reset while in REQ, lines held high across it
    bus.irq_in = 4'b0110; tick();
    tick(); tick();
    check("t6_pend", bus.pending, 4'b0110);
    tick();
    check("t6_req1", bus.int_req, 1);
    check("t6_id1",  bus.int_id,  1);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_req",  bus.int_req, 0);
    check("t6_rst_id",   bus.int_id,  0);
    check("t6_rst_pend", bus.pending, 0);
    check("t6_rst_ien",  bus.ien,     0);
    check("t6_rst_busy", bus.busy,    0);
    #9 reset = 1'b0;
    tick(); tick();
    check("t6_pend_b", bus.pending, 4'b0000);
    tick();
    check("t6_pend_c", bus.pending, 4'b0110);
    check("t6_req_c",  bus.int_req, 0);
    bus.ien_we = 1'b1; bus.ien_d = 4'hF; tick(); bus.ien_we = 1'b0;
    tick();
    check("t6_req1b", bus.int_req, 1);
    check("t6_id1b",  bus.int_id,  1);
    bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
    check("t6_pend_ack1", bus.pending, 4'b0100);
    tick(); tick();
    check("t6_pend_hold1", bus.pending, 4'b0100);
    bus.int_eoi = 1'b1; tick(); bus.int_eoi = 1'b0;
    tick();
    check("t6_req2", bus.int_req, 1);
    check("t6_id2",  bus.int_id,  2);
    bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
    tick(); tick(); tick();
    check("t6_pend_hold0", bus.pending, 4'b0000);
    bus.int_eoi = 1'b1; tick(); bus.int_eoi = 1'b0;
    bus.irq_in = '0;
    tick();
    check("t6_final_busy", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
